muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the HI/LO register pair and sits beside the EX-stage ALU. The pipeline raises `start` with rs/rt, stalls on `busy`, and reads HI/LO through `hi`/`lo` for MFHI/MFLO. All arithmetic is iterative: one shift-add or restoring-subtract step per cycle.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_seq.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative MIPS multiply/divide unit.
// Holds op and FSM encodings, the default operand width and the sizing of
// the iteration counter, plus small op-decoding helpers.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Iteration counter width: enough bits to hold 0..XLEN.
    localparam int CNT_W_DEFAULT = $clog2(XLEN_DEFAULT + 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

    // Bit 1 of the op separates divides from multiplies.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means the signed flavour (MULT / DIV).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Multiply: conditionally add the shifted multiplicand into the 2*XLEN product.
// Divide: restoring step; shift in the next dividend bit, subtract the divisor
// at XLEN+1 bits and keep the difference only when its sign bit is clear.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] addend_i,
    input  logic              mbit_i,
    input  logic [XLEN-1:0]   rem_i,
    input  logic              dvd_bit_i,
    input  logic [XLEN-1:0]   dvsr_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   rem_o,
    output logic              qbit_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Single shift-add or restoring-subtract step, selected by is_div_i.
    always_comb begin
        acc_o  = acc_i;
        rem_o  = rem_i;
        qbit_o = 1'b0;
        rem_sh = {rem_i, dvd_bit_i};
        diff   = rem_sh - {1'b0, dvsr_i};
        if (is_div_i) begin
            // rem_sh < 2*divisor, so both outcomes fit back into XLEN bits.
            if (!diff[XLEN]) begin
                rem_o  = diff[XLEN-1:0];
                qbit_o = 1'b1;
            end else begin
                rem_o  = rem_sh[XLEN-1:0];
            end
        end else if (mbit_i) begin
            acc_o = acc_i + addend_i;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for MULT/MULTU/DIV/DIVU owning HI/LO.
// Flow: IDLE -> PREP (magnitudes, signs) -> ITER (one step per cycle)
//       -> FIX (sign correction) -> FIN (HI/LO written, done pulse).
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies leave ITER once the
// remaining multiplier bits are all zero; divides keep fixed latency.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            dz,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int             CNT_W    = cnt_width(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    // Control state (reset)
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              dz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    // Operation datapath (not reset; always loaded before use)
    op_e               op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;      // mul: product; div: {remainder, quotient}
    logic [2*XLEN-1:0] sh_q;       // mul: shifted multiplicand; div: divisor
    logic [XLEN-1:0]   mplier_q;   // mul: remaining multiplier bits
    logic              neg_lo_q;   // negate product / quotient in FIX
    logic              neg_hi_q;   // negate remainder in FIX
    logic              dz_pend_q;

    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   step_rem;
    logic              step_qbit;

    // Absolute value computed at XLEN+1 bits so that |-2^(XLEN-1)| survives.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            neg);
        logic [XLEN:0] ext;
        ext = {neg, v};
        if (neg) begin
            ext = -ext;
        end
        return ext[XLEN-1:0];
    endfunction

    // Apply the recorded result signs; returns {HI, LO}.
    function automatic logic [2*XLEN-1:0] fix_result(input logic [2*XLEN-1:0] acc,
                                                     input logic              div,
                                                     input logic              neg_lo,
                                                     input logic              neg_hi);
        logic [XLEN-1:0] h;
        logic [XLEN-1:0] l;
        if (!div) begin
            return neg_lo ? -acc : acc;
        end
        h = acc[2*XLEN-1:XLEN];
        l = acc[XLEN-1:0];
        if (neg_hi) begin
            h = -h;
        end
        if (neg_lo) begin
            l = -l;
        end
        return {h, l};
    endfunction

    assign is_div = op_is_div(op_q);
    assign sgn_a  = op_is_signed(op_q) & a_q[XLEN-1];
    assign sgn_b  = op_is_signed(op_q) & b_q[XLEN-1];
    assign mag_a  = magnitude(a_q, sgn_a);
    assign mag_b  = magnitude(b_q, sgn_b);

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i  (is_div),
        .acc_i     (acc_q),
        .addend_i  (sh_q),
        .mbit_i    (mplier_q[0]),
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .dvd_bit_i (acc_q[XLEN-1]),
        .dvsr_i    (sh_q[XLEN-1:0]),
        .acc_o     (step_acc),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Sequencer FSM with registered busy/done/dz and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                // Not busy: accept a new operation (back-to-back from FIN)
                // or apply MTHI/MTLO.
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end else begin
                        if (mthi) begin
                            hi_q <= wdata;
                        end
                        if (mtlo) begin
                            lo_q <= wdata;
                        end
                        state_q <= ST_IDLE;
                    end
                end

                ST_PREP: begin
                    cnt_q <= '0;
                    if (is_div && (b_q == '0)) begin
                        // Divide by zero: HI keeps the dividend, LO all ones.
                        acc_q     <= {a_q, {XLEN{1'b1}}};
                        neg_lo_q  <= 1'b0;
                        neg_hi_q  <= 1'b0;
                        dz_pend_q <= 1'b1;
                        state_q   <= ST_FIX;
                    end else begin
                        neg_lo_q  <= sgn_a ^ sgn_b;
                        neg_hi_q  <= sgn_a;
                        dz_pend_q <= 1'b0;
                        if (is_div) begin
                            acc_q <= {{XLEN{1'b0}}, mag_a};
                            sh_q  <= {{XLEN{1'b0}}, mag_b};
                        end else begin
                            acc_q    <= '0;
                            sh_q     <= {{XLEN{1'b0}}, mag_a};
                            mplier_q <= mag_b;
                        end
                        state_q <= ST_ITER;
                    end
                end

                ST_ITER: begin
`ifdef MULDIV_EARLY_TERM_EN
                    if (!is_div && (mplier_q == '0)) begin
                        // Remaining multiplier bits are zero: product is final.
                        cnt_q   <= '0;
                        state_q <= ST_FIX;
                    end else
`endif
                    begin
                        if (is_div) begin
                            acc_q <= {step_rem, acc_q[XLEN-2:0], step_qbit};
                        end else begin
                            acc_q    <= step_acc;
                            sh_q     <= {sh_q[2*XLEN-2:0], 1'b0};
                            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                        end
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                // Sign correction lands directly in HI/LO as FIN is entered.
                ST_FIX: begin
                    {hi_q, lo_q} <= fix_result(acc_q, is_div, neg_lo_q, neg_hi_q);
                    done_q       <= 1'b1;
                    dz_q         <= dz_pend_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_FIN;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with a transaction-level model
// (64-bit arithmetic, latency table) checked every cycle, plus literal checks.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycles from the start edge until done is visible, for a multiply.
    function automatic int mul_lat(input logic [31:0] mb);
`ifdef MULDIV_EARLY_TERM_EN
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (mb[i]) n = i + 1;
        end
        return (n == 32) ? 34 : n + 3;
`else
        return 34;
`endif
    endfunction

    task automatic model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl,
                                output logic rdz, output int lat);
        logic signed [63:0] sp;
        logic [63:0]        up;
        rdz = 1'b0;
        lat = 34;
        case (o)
            2'b00: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                {rh, rl} = sp;
                lat = mul_lat(y[31] ? -y : y);
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                {rh, rl} = up;
                lat = mul_lat(y);
            end
            default: begin
                if (y == 32'd0) begin
                    rl = 32'hFFFF_FFFF; rh = x; rdz = 1'b1; lat = 2;
                end else if (o == 2'b11) begin
                    rl = x / y; rh = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 32'd0;
                end else begin
                    rl = $signed(x) / $signed(y); rh = $signed(x) % $signed(y);
                end
            end
        endcase
    endtask

    // Transaction-level reference: architectural HI/LO and one op in flight.
    int          cyc = 0;
    int          t0 = 0;
    int          m_lat = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [31:0] arch_hi = 32'd0;
    logic [31:0] arch_lo = 32'd0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            arch_hi = 32'd0; arch_lo = 32'd0;
        end else if (!m_busy) begin
            m_done = 1'b0; m_dz = 1'b0;
            if (start) begin
                model_result(op, a, b, r_hi, r_lo, r_dz, m_lat);
                t0 = cyc;
                m_busy = 1'b1;
            end else begin
                if (mthi) arch_hi = wdata;
                if (mtlo) arch_lo = wdata;
            end
        end else if (cyc == t0 + m_lat) begin
            arch_hi = r_hi; arch_lo = r_lo;
            m_busy = 1'b0; m_done = 1'b1; m_dz = r_dz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_dz", 32'(dz), 32'(m_dz));
            chk("cyc_hi", hi, arch_hi);
            chk("cyc_lo", lo, arch_lo);
        end
    end

    // Issue one op (DUT must be in IDLE or FIN) and wait for done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int elat, input string nm);
        int n;
        int nb;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, n, elat);
        chk({nm, "_busy"}, nb, elat);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_dz"}, 32'(dz), 32'(edz));
    endtask

    initial begin
        int n;
        int ndone;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'hA5A5_0001);
        chk("mt_both_lo", lo, 32'hA5A5_0001);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0,
              mul_lat(32'hFFFF_FFFF), "multu_max");
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0,
              mul_lat(32'd5), "mult_neg");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_neg");
        do_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 2, "divu_dz");
        @(posedge clk); #1;
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, "div_ovf");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, "div_pos_neg");
        do_op(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, 34, "div_neg_neg");
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "divu_100_7");
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0,
              mul_lat(32'h8000_0000), "mult_min_min");
        do_op(2'b00, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0,
              mul_lat(32'd1), "mult_min_one");
        do_op(2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 2, "div_dz");
        do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 34, "divu_max_1");
        do_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, mul_lat(32'd4), "b2b_multu");
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, "b2b_divu");

        // start/mthi while busy are ignored
        @(posedge clk); #1;
        op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd0; mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);
        mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h55);
        chk("mtlo_hi", hi, 32'd0);

        // reset in the middle of ITER aborts without a done
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", ndone, 32'd0);

`ifdef MULDIV_EARLY_TERM_EN
        do_op(2'b01, 32'd9, 32'd3, 32'd0, 32'd27, 1'b0, 5, "multu_early");
`else
        do_op(2'b01, 32'd9, 32'd3, 32'd0, 32'd27, 1'b0, 34, "multu_9x3");
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
